stream_argmax: RTL and testbench

//   Streaming arg-max for the network output layer. Takes NUM_CLASSES scores one

---
 rtl/stream_argmax.sv | 150 +++++++++++++++
 tb/tb_stream_argmax.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_argmax.sv
// ---------------------------------------------------------------------------
// stream_argmax
//   Streaming arg-max for the network output layer. NUM_CLASSES scores arrive
//   one beat per accepted handshake (beat k is class k). The block reports the
//   index and value of the largest score. Ties go to the lowest index.
//
//   Optional build macro: STREAM_ARGMAX_SIGNED_EN
//     defined   -> scores are two's complement and are compared as signed
//     undefined -> scores are unsigned magnitudes
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   clear      synchronous frame abort; has priority over both handshakes
//   in_valid   score beat valid
//   in_ready   block can accept a score (ACCUM state, low during rst)
//   in_data    score value
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   out_idx    index of the maximum score (registered)
//   out_max    value of the maximum score (registered)
//   busy       at least one beat of the current frame has been accepted
// ---------------------------------------------------------------------------
module stream_argmax #(
    parameter int DATA_W      = 8,
    parameter int NUM_CLASSES = 10,
    localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic              busy
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Count value of the beat that completes a frame.
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_t             state_reg,   state_next;
    logic [IDX_W-1:0]   count_reg,   count_next;
    logic [DATA_W-1:0]  best_reg,    best_next;
    logic [IDX_W-1:0]   idx_reg,     idx_next;
    logic [IDX_W-1:0]   out_idx_reg, out_idx_next;
    logic [DATA_W-1:0]  out_max_reg, out_max_next;

    logic               accept;
    logic               take;
    logic               new_is_greater;
    logic [DATA_W-1:0]  cand_best;
    logic [IDX_W-1:0]   cand_idx;

    // Strict comparison keeps the earlier (lower) index on ties.
`ifdef STREAM_ARGMAX_SIGNED_EN
    assign new_is_greater = $signed(in_data) > $signed(best_reg);
`else
    assign new_is_greater = in_data > best_reg;
`endif

    // Running best including the beat on the bus. Beat 0 always loads, so
    // whatever stale value is in best_reg never leaks into a new frame.
    assign cand_best = ((count_reg == '0) || new_is_greater) ? in_data   : best_reg;
    assign cand_idx  = ((count_reg == '0) || new_is_greater) ? count_reg : idx_reg;

    assign in_ready  = (state_reg == ACCUM) && !rst;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) && (count_reg != '0);
    assign out_idx   = out_idx_reg;
    assign out_max   = out_max_reg;

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ACCUM;
            count_reg   <= '0;
            best_reg    <= '0;
            idx_reg     <= '0;
            out_idx_reg <= '0;
            out_max_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            best_reg    <= best_next;
            idx_reg     <= idx_next;
            out_idx_reg <= out_idx_next;
            out_max_reg <= out_max_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        best_next    = best_reg;
        idx_next     = idx_reg;
        out_idx_next = out_idx_reg;
        out_max_next = out_max_reg;

        if (clear) begin
            // Abort wins over any beat or take in the same cycle.
            state_next   = ACCUM;
            count_next   = '0;
            best_next    = '0;
            idx_next     = '0;
            out_idx_next = '0;
            out_max_next = '0;
        end else begin
            unique case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (count_reg == LAST) begin
                            // Final beat still competes; publish the result.
                            state_next   = DONE;
                            count_next   = '0;
                            out_idx_next = cand_idx;
                            out_max_next = cand_best;
                        end else begin
                            count_next = count_reg + IDX_W'(1);
                            best_next  = cand_best;
                            idx_next   = cand_idx;
                        end
                    end
                end
                DONE: begin
                    // in_ready only returns the cycle after the take.
                    if (take) begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_argmax.sv
// ---------------------------------------------------------------------------
// tb_stream_argmax
//   Directed bench for stream_argmax (DATA_W=8, NUM_CLASSES=10). A table of
//   frames with hand-computed results is replayed, followed by hand-written
//   sequences for clear, reset mid-frame and reset while a result is pending.
//   Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_stream_argmax;

    localparam int DATA_W      = 8;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_max;
    logic              busy;

    stream_argmax #(
        .DATA_W      (DATA_W),
        .NUM_CLASSES (NUM_CLASSES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0][7:0] scores;   // scores[k] is class k
        logic [3:0]      exp_idx;
        logic [7:0]      exp_max;
        logic [3:0]      hold;     // cycles of out_ready=0 after the result
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [9:0][7:0] mk(
        input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
        input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5,
        input logic [7:0] s6, input logic [7:0] s7, input logic [7:0] s8,
        input logic [7:0] s9);
        logic [9:0][7:0] r;
        r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3; r[4] = s4;
        r[5] = s5; r[6] = s6; r[7] = s7; r[8] = s8; r[9] = s9;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one full frame, check the result timing/values, optionally hold
    // the result under backpressure with junk beats offered, then take it.
    task automatic run_frame(input vec_t v, input string tag);
        out_ready = (v.hold == 0);
        for (int k = 0; k < NUM_CLASSES; k++) begin
            in_valid = 1'b1;
            in_data  = v.scores[k];
            check({tag, " in_ready_beat"}, 32'(in_ready), 1);
            check({tag, " out_valid_beat"}, 32'(out_valid), 0);
            tick();
            if (k == 0) check({tag, " busy_after_beat0"}, 32'(busy), 1);
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 1);
        check({tag, " out_idx"}, 32'(out_idx), 32'(v.exp_idx));
        check({tag, " out_max"}, 32'(out_max), 32'(v.exp_max));
        check({tag, " in_ready_done"}, 32'(in_ready), 0);
        check({tag, " busy_done"}, 32'(busy), 0);
        for (int h = 0; h < int'(v.hold); h++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            check({tag, " hold_out_valid"}, 32'(out_valid), 1);
            check({tag, " hold_out_idx"}, 32'(out_idx), 32'(v.exp_idx));
            check({tag, " hold_out_max"}, 32'(out_max), 32'(v.exp_max));
            check({tag, " hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, " out_valid_after_take"}, 32'(out_valid), 0);
        check({tag, " in_ready_after_take"}, 32'(in_ready), 1);
        $display("frame %s: idx=%0d max=0x%02h (expected idx=%0d max=0x%02h) hold=%0d",
                 tag, v.exp_idx, v.exp_max, v.exp_idx, v.exp_max, v.hold);
    endtask

    initial begin
        vecs[0] = '{scores: mk(9, 7, 6, 15, 13, 17, 20, 7, 1, 2),
                    exp_idx: 4'd6, exp_max: 8'd20, hold: 4'd0};
        vecs[1] = '{scores: mk(8'h11, 8'h22, 8'h33, 8'h7F, 8'h7E, 0, 0, 0, 0, 0),
                    exp_idx: 4'd3, exp_max: 8'h7F, hold: 4'd8};
        vecs[2] = '{scores: mk(5, 5, 5, 5, 5, 5, 5, 5, 5, 5),
                    exp_idx: 4'd0, exp_max: 8'd5, hold: 4'd0};
        vecs[3] = '{scores: mk(3, 9, 9, 1, 0, 0, 0, 0, 0, 0),
                    exp_idx: 4'd1, exp_max: 8'd9, hold: 4'd0};
`ifdef STREAM_ARGMAX_SIGNED_EN
        vecs[4] = '{scores: mk(0, 0, 8'h80, 0, 0, 8'h01, 0, 0, 0, 0),
                    exp_idx: 4'd5, exp_max: 8'h01, hold: 4'd0};
`else
        vecs[4] = '{scores: mk(0, 0, 8'h80, 0, 0, 8'h01, 0, 0, 0, 0),
                    exp_idx: 4'd2, exp_max: 8'h80, hold: 4'd0};
`endif
        vecs[5] = '{scores: mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10),
                    exp_idx: 4'd9, exp_max: 8'd10, hold: 4'd0};
        vecs[6] = '{scores: mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF),
                    exp_idx: 4'd0, exp_max: 8'hFF, hold: 4'd0};

        // Reset state.
        #2;
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst out_idx", 32'(out_idx), 0);
        check("rst out_max", 32'(out_max), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst in_ready", 32'(in_ready), 1);
        $display("reset: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // clear after 4 beats; beat offered during clear must be dropped.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(10 * (k + 1));
            tick();
        end
        check("clr busy_before", 32'(busy), 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr busy_after", 32'(busy), 0);
        check("clr out_valid", 32'(out_valid), 0);
        check("clr out_idx", 32'(out_idx), 0);
        check("clr out_max", 32'(out_max), 0);
        $display("clear: busy=%0b out_valid=%0b out_max=0x%02h", busy, out_valid, out_max);
        run_frame('{scores: mk(1, 2, 3, 4, 5, 6, 7, 8, 8'h40, 9),
                    exp_idx: 4'd8, exp_max: 8'h40, hold: 4'd0}, "after_clear");

        // rst mid-frame: partial frame discarded, outputs reset immediately.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h70;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid busy", 32'(busy), 0);
        check("rst_mid in_ready", 32'(in_ready), 0);
        check("rst_mid out_valid", 32'(out_valid), 0);
        check("rst_mid out_max", 32'(out_max), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid out_valid_later", 32'(out_valid), 0);
        check("rst_mid in_ready_later", 32'(in_ready), 1);
        $display("rst mid-frame: busy=%0b out_valid=%0b", busy, out_valid);
        run_frame(vecs[0], "after_rst_mid");

        // rst while a result is pending.
        out_ready = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            in_valid = 1'b1;
            in_data  = vecs[0].scores[k];
            tick();
        end
        in_valid = 1'b0;
        check("rst_done out_valid_before", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_done out_valid", 32'(out_valid), 0);
        check("rst_done out_idx", 32'(out_idx), 0);
        check("rst_done out_max", 32'(out_max), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_done no_stale", 32'(out_valid), 0);
        end
        $display("rst while done: out_valid=%0b out_idx=%0d out_max=0x%02h",
                 out_valid, out_idx, out_max);
        run_frame(vecs[3], "after_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
